async_fifo_rd_stream: RTL and testbench

- Read-side adapter between the async_fifo read port (rd_en/rd_data/empty) and a valid/ready stream consumer, entirely in the read clock domain.
- Issues FIFO reads from credits, absorbs the fixed FIFO read latency in a small skid buffer, and sustains one word per cycle under continuous ready.
- Never reads an empty FIFO.

---
 rtl/async_fifo_pkg.sv | 14 +
 rtl/async_fifo_skid_buf.sv | 77 +++++++
 rtl/async_fifo_rd_stream.sv | 87 ++++++++
 tb/tb_async_fifo_rd_stream.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the async_fifo read-side stream adapter.
//   MAX_RD_LATENCY : largest supported FIFO read latency
//   MAX_SKID_DEPTH : largest supported skid buffer depth
//   clog2_min1     : ceil(log2(n)) clamped to at least 1, for counter/pointer widths
package async_fifo_pkg;

  localparam int unsigned MAX_RD_LATENCY = 3;
  localparam int unsigned MAX_SKID_DEPTH = 8;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/async_fifo_skid_buf.sv
// Circular skid buffer for the async_fifo read stream adapter.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   clear           : synchronous discard of all entries (wins over push/pop)
//   push, push_data : write push_data at the write pointer
//   pop             : retire the head entry
//   head_data       : entry at the read pointer
//   valid           : registered "buffer not empty"
//   count           : number of stored entries
module async_fifo_skid_buf
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                push,
  input  logic [DATA_WIDTH-1:0]               push_data,
  input  logic                                pop,
  output logic [DATA_WIDTH-1:0]               head_data,
  output logic                                valid,
  output logic [clog2_min1(DEPTH+1)-1:0]      count
);

  localparam int unsigned PtrW = clog2_min1(DEPTH);
  localparam int unsigned CntW = clog2_min1(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  valid_q;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      if (push && !clear) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign valid     = valid_q;
  assign count     = count_q;

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter: async_fifo read port (rd_en/rd_data/empty) to valid/ready stream.
// Reads are issued only against free skid-buffer credits, so the fixed FIFO read
// latency is absorbed without ever overflowing the buffer.
// Ports:
//   rd_clk, rst    : read clock, asynchronous active-high reset
//   flush          : synchronous discard of buffered and in-flight words
//   fifo_empty     : FIFO empty flag
//   fifo_rd_data   : FIFO read data, valid RD_LATENCY edges after fifo_rd_en
//   fifo_rd_en     : FIFO read enable
//   m_valid/m_data : stream output, m_data is the skid buffer head
//   m_ready        : stream consumer ready
//   buf_count      : stored entries
//   inflight       : issued reads not yet captured
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned SKID_DEPTH = 3
) (
  input  logic                                    rd_clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic                                    fifo_empty,
  input  logic [DATA_WIDTH-1:0]                   fifo_rd_data,
  output logic                                    fifo_rd_en,
  output logic                                    m_valid,
  output logic [DATA_WIDTH-1:0]                   m_data,
  input  logic                                    m_ready,
  output logic [clog2_min1(SKID_DEPTH+1)-1:0]     buf_count,
  output logic [clog2_min1(RD_LATENCY+2)-1:0]     inflight
);

  localparam int unsigned InflW = clog2_min1(RD_LATENCY + 2);

  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [4:0]            credit_used;
  logic                  capture;
  logic                  pop;

  // Credits: everything stored plus everything still returning from the FIFO.
  always_comb begin
    credit_used = 5'(buf_count) + 5'(inflight);
    fifo_rd_en  = !rst && !flush && !fifo_empty && (credit_used < 5'(SKID_DEPTH));
  end

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = fifo_rd_en;
    for (int i = 1; i < int'(RD_LATENCY); i++) pipe_d[i] = pipe_q[i-1];
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) inflight = inflight + InflW'(pipe_q[i]);
  end

  // Flushing the pipe drops words already requested from the FIFO; they are lost.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else if (flush) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign capture = pipe_q[RD_LATENCY-1];
  assign pop     = m_valid && m_ready;

  async_fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid_buf (
    .clk       (rd_clk),
    .rst       (rst),
    .clear     (flush),
    .push      (capture),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head_data (m_data),
    .valid     (m_valid),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
module tb_async_fifo_rd_stream;

  logic       rd_clk = 1'b0;
  logic       rst    = 1'b1;
  always #5 rd_clk = ~rd_clk;

  // Instance A: defaults (latency 1, depth 3). Instance B: latency 2, depth 4.
  logic       flush_a = 1'b0, flush_b = 1'b0;
  logic       empty_a = 1'b1, empty_b = 1'b1;
  logic [7:0] rdata_a = 8'h00, rdata_b = 8'h00, chain_b = 8'h00;
  logic       rd_en_a, rd_en_b;
  logic       valid_a, valid_b;
  logic [7:0] data_a, data_b;
  logic       m_ready_a = 1'b1, m_ready_b = 1'b1;
  logic [1:0] cnt_a, infl_a, infl_b;
  logic [2:0] cnt_b;

  async_fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(1), .SKID_DEPTH(3)) u_dut_a (
    .rd_clk(rd_clk), .rst(rst), .flush(flush_a), .fifo_empty(empty_a),
    .fifo_rd_data(rdata_a), .fifo_rd_en(rd_en_a), .m_valid(valid_a), .m_data(data_a),
    .m_ready(m_ready_a), .buf_count(cnt_a), .inflight(infl_a)
  );

  async_fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(2), .SKID_DEPTH(4)) u_dut_b (
    .rd_clk(rd_clk), .rst(rst), .flush(flush_b), .fifo_empty(empty_b),
    .fifo_rd_data(rdata_b), .fifo_rd_en(rd_en_b), .m_valid(valid_b), .m_data(data_b),
    .m_ready(m_ready_b), .buf_count(cnt_b), .inflight(infl_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] fq_a[$], fq_b[$];
  logic [7:0] got_a[$], got_b[$];
  int         gcyc_a[$], gcyc_b[$];
  int         rdcnt_a = 0;
  logic       hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0] held_a = 8'h00, held_b = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] w);
    fq_a.push_back(w);
    empty_a = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] w);
    fq_b.push_back(w);
    empty_b = 1'b0;
  endtask

  task automatic clear_a();
    got_a.delete();
    gcyc_a.delete();
  endtask

  // Behavioural FIFO: a read request pops the head; data shows up RD_LATENCY edges later.
  always @(posedge rd_clk) begin
    logic [7:0] wa, wb;
    cyc = cyc + 1;
    wa  = 8'hEE;
    wb  = 8'hEE;
    if (rd_en_a && fq_a.size() != 0) wa = fq_a.pop_front();
    if (rd_en_b && fq_b.size() != 0) wb = fq_b.pop_front();
    rdata_a <= wa;
    chain_b <= wb;
    rdata_b <= chain_b;
    empty_a <= (fq_a.size() == 0);
    empty_b <= (fq_b.size() == 0);
  end

  // Per-cycle invariants and transfer recording, sampled mid-cycle.
  always @(negedge rd_clk) begin
    chk("credit_a", 32'((32'(cnt_a) + 32'(infl_a)) <= 3), 32'd1);
    chk("credit_b", 32'((32'(cnt_b) + 32'(infl_b)) <= 4), 32'd1);
    chk("rd_while_empty_a", 32'(rd_en_a && empty_a), 32'd0);
    chk("rd_while_empty_b", 32'(rd_en_b && empty_b), 32'd0);
    if (hold_a && !rst) begin
      chk("hold_valid_a", 32'(valid_a), 32'd1);
      chk("hold_data_a", 32'(data_a), 32'(held_a));
    end
    if (hold_b && !rst) begin
      chk("hold_valid_b", 32'(valid_b), 32'd1);
      chk("hold_data_b", 32'(data_b), 32'(held_b));
    end
    hold_a = valid_a && !m_ready_a && !flush_a && !rst;
    held_a = data_a;
    hold_b = valid_b && !m_ready_b && !flush_b && !rst;
    held_b = data_b;
    if (rd_en_a) rdcnt_a++;
    if (valid_a && m_ready_a && !rst) begin
      got_a.push_back(data_a);
      gcyc_a.push_back(cyc);
    end
    if (valid_b && m_ready_b && !rst) begin
      got_b.push_back(data_b);
      gcyc_b.push_back(cyc);
    end
  end

  initial begin
    int t;
    int n;
    logic [7:0] exp_q[$];
    logic [7:0] w;

    // Reset held, then idle with an empty FIFO.
    repeat (20) tick();
    chk("rst_rd_en", 32'(rd_en_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_inflight", 32'(infl_a), 32'd0);
    chk("rst_valid_b", 32'(valid_b), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_rd_en", 32'(rd_en_a), 32'd0);
      chk("idle_valid", 32'(valid_a), 32'd0);
      chk("idle_count", 32'(cnt_a), 32'd0);
      chk("idle_inflight", 32'(infl_a), 32'd0);
    end

    // Single word: read issued same cycle, visible two cycles later for one cycle.
    clear_a();
    t = cyc;
    push_a(8'hAB);
    #1;
    chk("single_rd_en_t", 32'(rd_en_a), 32'd1);
    tick();
    chk("single_rd_en_t1", 32'(rd_en_a), 32'd0);
    chk("single_valid_t1", 32'(valid_a), 32'd0);
    chk("single_infl_t1", 32'(infl_a), 32'd1);
    tick();
    chk("single_valid_t2", 32'(valid_a), 32'd1);
    chk("single_data_t2", 32'(data_a), 32'hAB);
    tick();
    chk("single_valid_t3", 32'(valid_a), 32'd0);
    chk("single_n", 32'(got_a.size()), 32'd1);
    if (got_a.size() == 1) chk("single_cycle", 32'(gcyc_a[0]), 32'(t + 2));

    // Streaming: 16 words, one transfer per cycle after fill latency.
    clear_a();
    t = cyc;
    for (int i = 0; i < 16; i++) push_a(8'(i));
    repeat (25) tick();
    chk("stream_n", 32'(got_a.size()), 32'd16);
    if (got_a.size() == 16)
      for (int i = 0; i < 16; i++) begin
        chk("stream_data", 32'(got_a[i]), 32'(i));
        chk("stream_cycle", 32'(gcyc_a[i]), 32'(t + 2 + i));
      end

    // Backpressure: only SKID_DEPTH reads issued while m_ready is low.
    clear_a();
    rdcnt_a   = 0;
    m_ready_a = 1'b0;
    for (int i = 0; i < 16; i++) push_a(8'(i));
    repeat (10) tick();
    chk("bp_reads", 32'(rdcnt_a), 32'd3);
    chk("bp_count", 32'(cnt_a), 32'd3);
    chk("bp_inflight", 32'(infl_a), 32'd0);
    chk("bp_valid", 32'(valid_a), 32'd1);
    chk("bp_data", 32'(data_a), 32'h00);
    chk("bp_none_out", 32'(got_a.size()), 32'd0);
    m_ready_a = 1'b1;
    repeat (30) tick();
    chk("bp_n", 32'(got_a.size()), 32'd16);
    if (got_a.size() == 16)
      for (int i = 0; i < 16; i++) chk("bp_order", 32'(got_a[i]), 32'(i));

    // Flush one cycle after a read on the latency-2 instance: that word is lost.
    got_b.delete();
    gcyc_b.delete();
    t = cyc;
    push_b(8'h11);
    push_b(8'h12);
    #1;
    chk("fl_rd_en_t", 32'(rd_en_b), 32'd1);
    tick();
    flush_b = 1'b1;
    #1;
    chk("fl_rd_en_flush", 32'(rd_en_b), 32'd0);
    chk("fl_infl_before", 32'(infl_b), 32'd1);
    tick();
    flush_b = 1'b0;
    chk("fl_valid_after", 32'(valid_b), 32'd0);
    chk("fl_count_after", 32'(cnt_b), 32'd0);
    chk("fl_infl_after", 32'(infl_b), 32'd0);
    #1;
    chk("fl_next_rd", 32'(rd_en_b), 32'd1);
    repeat (10) tick();
    chk("fl_n", 32'(got_b.size()), 32'd1);
    if (got_b.size() == 1) begin
      chk("fl_word", 32'(got_b[0]), 32'h12);
      chk("fl_cycle", 32'(gcyc_b[0]), 32'(t + 5));
    end

    // Asynchronous reset between edges while two words are buffered.
    clear_a();
    m_ready_a = 1'b0;
    for (int i = 0; i < 4; i++) push_a(8'(8'h30 + i));
    n = 0;
    while (cnt_a != 2 && n < 10) begin
      tick();
      n++;
    end
    chk("arst_reach_count2", 32'(n < 10), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_a), 32'd0);
    chk("arst_count", 32'(cnt_a), 32'd0);
    chk("arst_rd_en", 32'(rd_en_a), 32'd0);
    chk("arst_inflight", 32'(infl_a), 32'd0);
    chk("arst_data", 32'(data_a), 32'd0);
    fq_a.delete();
    empty_a = 1'b1;
    repeat (2) tick();
    rst       = 1'b0;
    m_ready_a = 1'b1;
    tick();
    clear_a();

    // Random traffic: random arrivals and random backpressure, order must be kept.
    exp_q.delete();
    for (int c = 0; c < 800 && got_a.size() < 60; c++) begin
      if (exp_q.size() < 60 && $urandom_range(0, 1) == 1) begin
        w = 8'($urandom);
        exp_q.push_back(w);
        push_a(w);
      end
      m_ready_a = ($urandom_range(0, 3) != 0);
      tick();
    end
    m_ready_a = 1'b1;
    chk("rand_n", 32'(got_a.size()), 32'd60);
    if (got_a.size() == 60 && exp_q.size() == 60)
      for (int i = 0; i < 60; i++) chk("rand_data", 32'(got_a[i]), 32'(exp_q[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
